wb_master_engine: RTL

- Single-transaction Wishbone B3 classic master. Converts the start/address/selection/write/data_wr command handshake into one bus cycle, then returns read data and status.
- The DSP top instantiates one copy per bus master, for the daq and cpu ports.
- Sits between the command source (bench tasks or a DAQ sequencer) and the Wishbone interconnect/arbiter. Supports bounded retry on rty and an optional response timeout.

---
 rtl/wb_master_engine_if.sv | 50 +++++
 rtl/wb_master_engine.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/wb_master_engine_if.sv
// ============================================================================
// wb_master_engine_if : command handshake + Wishbone B3 classic bus bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface wb_master_engine_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int SEL_WIDTH = DATA_WIDTH / 8;

   logic                  start;
   logic [ADDR_WIDTH-1:0] address;
   logic [SEL_WIDTH-1:0]  selection;
   logic                  write;
   logic [DATA_WIDTH-1:0] data_wr;
   logic [DATA_WIDTH-1:0] data_rd;
   logic                  active;
   logic                  done;
   logic                  error;
   logic                  timeout;

   logic [ADDR_WIDTH-1:0] wb_adr_o;
   logic [DATA_WIDTH-1:0] wb_dat_o;
   logic [SEL_WIDTH-1:0]  wb_sel_o;
   logic                  wb_we_o;
   logic                  wb_cyc_o;
   logic                  wb_stb_o;
   logic [DATA_WIDTH-1:0] wb_dat_i;
   logic                  wb_ack_i;
   logic                  wb_err_i;
   logic                  wb_rty_i;

   modport master (
      input  start, address, selection, write, data_wr,
      input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
      output data_rd, active, done, error, timeout,
      output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
   );

   modport slave (
      output start, address, selection, write, data_wr,
      output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
      input  data_rd, active, done, error, timeout,
      input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
   );
endinterface

`default_nettype wire

// File: rtl/wb_master_engine.sv
// ============================================================================
// wb_master_engine : single-transaction Wishbone B3 classic master with
// bounded rty retry. Optional response timeout: define WB_MASTER_TIMEOUT_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module wb_master_engine #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int MAX_RETRY      = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  wire logic          wb_clk,
   input  wire logic          wb_rst,
   wb_master_engine_if.master bus
);
   localparam int SEL_WIDTH = DATA_WIDTH / 8;
   localparam int RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUS   = 2'd1,
      S_RETRY = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                state_q,   state_d;
   logic [RETRY_W-1:0]    retry_q,   retry_d;
   logic [ADDR_WIDTH-1:0] adr_q,     adr_d;
   logic [DATA_WIDTH-1:0] dat_q,     dat_d;
   logic [SEL_WIDTH-1:0]  sel_q,     sel_d;
   logic                  we_q,      we_d;
   logic                  cyc_q,     cyc_d;
   logic [DATA_WIDTH-1:0] data_rd_q, data_rd_d;
   logic                  active_q,  active_d;
   logic                  done_q,    done_d;
   logic                  error_q,   error_d;

`ifdef WB_MASTER_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WAIT_W-1:0]     wait_q,    wait_d;
   logic                  timeout_q, timeout_d;
`endif

   always_comb begin
      state_d   = state_q;
      retry_d   = retry_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      sel_d     = sel_q;
      we_d      = we_q;
      cyc_d     = cyc_q;
      data_rd_d = data_rd_q;
      active_d  = active_q;
      done_d    = 1'b0;
      error_d   = error_q;
`ifdef WB_MASTER_TIMEOUT_EN
      wait_d    = wait_q;
      timeout_d = timeout_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               adr_d    = bus.address;
               dat_d    = bus.data_wr;
               sel_d    = bus.selection;
               we_d     = bus.write;
               cyc_d    = 1'b1;
               active_d = 1'b1;
               error_d  = 1'b0;
               retry_d  = '0;
               state_d  = S_BUS;
`ifdef WB_MASTER_TIMEOUT_EN
               wait_d    = '0;
               timeout_d = 1'b0;
`endif
            end
         end
         S_BUS: begin
`ifdef WB_MASTER_TIMEOUT_EN
            wait_d = wait_q + 1'b1;
`endif
            // err outranks ack, which outranks rty
            if (bus.wb_err_i) begin
               cyc_d   = 1'b0;
               error_d = 1'b1;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (bus.wb_ack_i) begin
               cyc_d   = 1'b0;
               if (!we_q) data_rd_d = bus.wb_dat_i;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (bus.wb_rty_i) begin
               cyc_d = 1'b0;
               if (retry_q < RETRY_W'(MAX_RETRY)) begin
                  retry_d = retry_q + 1'b1;
                  state_d = S_RETRY;
               end else begin
                  error_d = 1'b1;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
`ifdef WB_MASTER_TIMEOUT_EN
            else if ((wait_q + 1'b1) == WAIT_W'(TIMEOUT_CYCLES)) begin
               cyc_d     = 1'b0;
               error_d   = 1'b1;
               timeout_d = 1'b1;
               done_d    = 1'b1;
               state_d   = S_DONE;
            end
`endif
         end
         S_RETRY: begin
            cyc_d   = 1'b1;
            state_d = S_BUS;
`ifdef WB_MASTER_TIMEOUT_EN
            wait_d  = '0;
`endif
         end
         S_DONE: begin
            active_d = 1'b0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state_q   <= S_IDLE;
         retry_q   <= '0;
         adr_q     <= '0;
         dat_q     <= '0;
         sel_q     <= '0;
         we_q      <= 1'b0;
         cyc_q     <= 1'b0;
         data_rd_q <= '0;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
         wait_q    <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         retry_q   <= retry_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         sel_q     <= sel_d;
         we_q      <= we_d;
         cyc_q     <= cyc_d;
         data_rd_q <= data_rd_d;
         active_q  <= active_d;
         done_q    <= done_d;
         error_q   <= error_d;
`ifdef WB_MASTER_TIMEOUT_EN
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign bus.wb_adr_o = adr_q;
   assign bus.wb_dat_o = dat_q;
   assign bus.wb_sel_o = sel_q;
   assign bus.wb_we_o  = we_q;
   assign bus.wb_cyc_o = cyc_q;
   assign bus.wb_stb_o = cyc_q;
   assign bus.data_rd  = data_rd_q;
   assign bus.active   = active_q;
   assign bus.done     = done_q;
   assign bus.error    = error_q;
`ifdef WB_MASTER_TIMEOUT_EN
   assign bus.timeout  = timeout_q;
`else
   assign bus.timeout  = 1'b0;
`endif

endmodule

`default_nettype wire
